roic_serial_tx: RTL and testbench



---
 rtl/roic_tx_pkg.sv | 17 +
 rtl/roic_word_serializer.sv | 58 +++++
 rtl/roic_serial_tx.sv | 181 ++++++++++++++++++
 tb/tb_roic_serial_tx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roic_tx_pkg.sv
// Shared types and constants for the ROIC serial transmitter: FSM states,
// default alignment patterns and word geometry.
package roic_tx_pkg;

    localparam int unsigned  BITS_PER_WORD  = 24;
    localparam int unsigned  FCLK_HIGH_BITS = BITS_PER_WORD / 2;
    localparam logic [23:0]  PATTERN_1_DEF  = 24'hFFF000;
    localparam logic [23:0]  PATTERN_2_DEF  = 24'hFF0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_HEADER = 2'd2,
        ST_DATA   = 2'd3
    } tx_state_e;

endpackage

// File: rtl/roic_word_serializer.sv
// Free-running word serializer: MSB-first shift register, bit counter, word
// boundary strobe and bit-aligned registered data / frame-clock outputs.
module roic_word_serializer
    import roic_tx_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = BITS_PER_WORD,
    parameter logic [DATA_WIDTH-1:0] RESET_WORD = PATTERN_1_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] load_word_i,
    output logic                  boundary_o,
    output logic                  sdata_o,
    output logic                  fclk_o
);

    localparam int unsigned    CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]  HALF     = CW'(DATA_WIDTH / 2);
    localparam logic [CW-1:0]  ONE      = CW'(1);

    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  sdata_q, fclk_q;

    assign boundary_o = (bit_cnt_q == LAST_BIT);
    assign sdata_o    = sdata_q;
    assign fclk_o     = fclk_q;

    // Next bit position and shift contents; a new word replaces the shifter at the boundary.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (boundary_o) begin
            bit_cnt_d = '0;
            shift_d   = load_word_i;
        end else begin
            bit_cnt_d = bit_cnt_q + ONE;
            shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Shifter, counter and output registers; data and fclk share one stage so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            shift_q   <= RESET_WORD;
            sdata_q   <= 1'b0;
            fclk_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sdata_q   <= shift_q[DATA_WIDTH-1];
            fclk_q    <= (bit_cnt_q < HALF);
        end
    end

endmodule

// File: rtl/roic_serial_tx.sv
// ROIC output serializer top: request capture, idle/train/header/data word
// sequencing and a one-deep source holding register feeding the serializer.
module roic_serial_tx
    import roic_tx_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = BITS_PER_WORD,
    parameter logic [DATA_WIDTH-1:0] PATTERN_1   = PATTERN_1_DEF,
    parameter logic [DATA_WIDTH-1:0] PATTERN_2   = PATTERN_2_DEF,
    parameter int unsigned           CHANNELS    = 256,
    parameter int unsigned           TRAIN_WORDS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  train_req,
    input  logic                  frame_start,
    input  logic                  test_ramp_en,
    input  logic [DATA_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  sdata_out,
    output logic                  fclk_out,
    output logic                  busy,
    output logic                  train_done,
    output logic                  frame_done,
    output logic                  underflow
);

    localparam int unsigned     CH_W    = $clog2(CHANNELS + 1);
    localparam int unsigned     TR_W    = $clog2(TRAIN_WORDS + 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
    localparam logic [TR_W-1:0] TR_LAST = TR_W'(TRAIN_WORDS - 1);

    tx_state_e             state_q, state_d;
    logic                  train_pend_q, train_pend_d, frame_pend_q, frame_pend_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  ramp_q, ramp_d;
    logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d;
    logic [TR_W-1:0]       tr_cnt_q, tr_cnt_d;
    logic                  underflow_q, underflow_d;
    logic                  train_done_q, train_done_d, frame_done_q, frame_done_d;
    logic                  busy_q, busy_d;
    logic                  boundary_s, ramp_s, take_train_s, take_frame_s, consume_s, xfer_s;
    logic [DATA_WIDTH-1:0] load_word_s, data_word_s;

    roic_word_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_WORD (PATTERN_1)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_word_i (load_word_s),
        .boundary_o  (boundary_s),
        .sdata_o     (sdata_out),
        .fclk_o      (fclk_out)
    );

    // Word sequencing: everything changes only at a word boundary.
    always_comb begin
        state_d      = state_q;
        tr_cnt_d     = tr_cnt_q;
        ch_cnt_d     = ch_cnt_q;
        ramp_d       = ramp_q;
        underflow_d  = underflow_q;
        train_done_d = 1'b0;
        frame_done_d = 1'b0;
        take_train_s = 1'b0;
        take_frame_s = 1'b0;
        consume_s    = 1'b0;
        load_word_s  = PATTERN_1;
        // The ramp select is latched at the header-to-data boundary and held for the line.
        ramp_s       = (state_q == ST_HEADER) ? test_ramp_en : ramp_q;
        if (ramp_s) begin
            data_word_s = DATA_WIDTH'(ch_cnt_q);
        end else if (hold_valid_q) begin
            data_word_s = hold_data_q;
        end else begin
            data_word_s = '0;
        end
        if (boundary_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (train_pend_q) begin
                        take_train_s = 1'b1;
                        state_d      = ST_TRAIN;
                        tr_cnt_d     = TR_W'(1);
                        load_word_s  = PATTERN_1;
                    end else if (frame_pend_q) begin
                        take_frame_s = 1'b1;
                        state_d      = ST_HEADER;
                        ch_cnt_d     = '0;
                        load_word_s  = PATTERN_2;
                    end else begin
                        load_word_s  = PATTERN_1;
                    end
                end
                ST_TRAIN: begin
                    load_word_s = tr_cnt_q[0] ? PATTERN_2 : PATTERN_1;
                    tr_cnt_d    = tr_cnt_q + TR_W'(1);
                    if (tr_cnt_q == TR_LAST) begin
                        state_d      = ST_IDLE;
                        train_done_d = 1'b1;
                    end else begin
                        state_d      = ST_TRAIN;
                    end
                end
                ST_HEADER, ST_DATA: begin
                    load_word_s = data_word_s;
                    ch_cnt_d    = ch_cnt_q + CH_W'(1);
                    ramp_d      = ramp_s;
                    if (ramp_s) begin
                        consume_s   = 1'b0;
                    end else begin
                        consume_s   = hold_valid_q;
                        underflow_d = underflow_q | ~hold_valid_q;
                    end
                    if (ch_cnt_q == CH_LAST) begin
                        state_d      = ST_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d      = ST_DATA;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    load_word_s = PATTERN_1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Request flags and holding register; a repeated pulse on a pending flag is absorbed.
    always_comb begin
        train_pend_d = take_train_s ? 1'b0 : (train_pend_q | train_req);
        frame_pend_d = take_frame_s ? 1'b0 : (frame_pend_q | frame_start);
        xfer_s       = word_valid & ~hold_valid_q;
        hold_valid_d = xfer_s | (hold_valid_q & ~consume_s);
        hold_data_d  = xfer_s ? word_data : hold_data_q;
        busy_d       = (state_d != ST_IDLE);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            train_pend_q <= 1'b0;
            frame_pend_q <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            ramp_q       <= 1'b0;
            ch_cnt_q     <= '0;
            tr_cnt_q     <= '0;
            underflow_q  <= 1'b0;
            train_done_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            train_pend_q <= train_pend_d;
            frame_pend_q <= frame_pend_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            ramp_q       <= ramp_d;
            ch_cnt_q     <= ch_cnt_d;
            tr_cnt_q     <= tr_cnt_d;
            underflow_q  <= underflow_d;
            train_done_q <= train_done_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign word_ready = ~hold_valid_q;
    assign busy       = busy_q;
    assign train_done = train_done_q;
    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_roic_serial_tx.sv
// Self-checking bench for roic_serial_tx: pin words are reassembled from the
// serial stream and compared with word sequences derived from the line rules.
module tb_roic_serial_tx;

    localparam logic [23:0] P1 = 24'hFFF000;
    localparam logic [23:0] P2 = 24'hFF0000;
    localparam int          CH = 256;
    localparam int          TW = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        train_req = 1'b0, frame_start = 1'b0, test_ramp_en = 1'b0;
    logic [23:0] word_data = 24'h000000;
    logic        word_valid = 1'b0;
    logic        word_ready, sdata_out, fclk_out, busy, train_done, frame_done, underflow;

    int          n_pass = 0;
    int          n_chk  = 0;
    int          ecnt   = 0;
    logic [23:0] cur_d = 24'h000000, cur_f = 24'h000000;
    logic [23:0] words[$];
    logic [23:0] fwords[$];
    logic [23:0] exp_w[$];
    logic [23:0] src_vals[$];
    int          src_idx = 0, stall_after = 0, resume_edge = 0;
    bit          src_on = 1'b0;

    always #5 clk = ~clk;

    roic_serial_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .train_req    (train_req),
        .frame_start  (frame_start),
        .test_ramp_en (test_ramp_en),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .sdata_out    (sdata_out),
        .fclk_out     (fclk_out),
        .busy         (busy),
        .train_done   (train_done),
        .frame_done   (frame_done),
        .underflow    (underflow)
    );

    // Rising edges since reset release; pin slot n occupies edges 24n+1 .. 24n+24.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    // Reassemble pin words (data and frame clock) on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            words.delete();
            fwords.delete();
        end else if (ecnt >= 1) begin
            cur_d <= {cur_d[22:0], sdata_out};
            cur_f <= {cur_f[22:0], fclk_out};
            if ((ecnt - 1) % 24 == 23) begin
                words.push_back({cur_d[22:0], sdata_out});
                fwords.push_back({cur_f[22:0], fclk_out});
            end
        end
    end

    // Source: presents src_vals in order, withholding values past stall_after until resume_edge.
    initial begin : source
        bit xfer;
        forever begin
            @(posedge clk);
            xfer = rst_n && word_valid && word_ready;
            #1;
            if (xfer) src_idx++;
            if (src_on && src_idx < src_vals.size() &&
                (src_idx < stall_after || ecnt >= resume_edge - 1)) begin
                word_valid = 1'b1;
                word_data  = src_vals[src_idx];
            end else begin
                word_valid = 1'b0;
                word_data  = 24'h000000;
            end
        end
    end

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, expv);
    endtask

    task automatic goto_edge(input int k);
        int guard = 0;
        while (ecnt < k && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (ecnt != k) chk("goto_edge", k, ecnt, k);
    endtask

    task automatic pulse_req(input bit tr, input bit fr, input int s);
        goto_edge(s - 1);
        train_req   = tr;
        frame_start = fr;
        @(posedge clk);
        #1;
        train_req   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic check_slots(input string tag);
        int guard = 0;
        while (words.size() < exp_w.size() && guard < 30000) begin
            @(posedge clk);
            guard++;
        end
        if (words.size() < exp_w.size()) chk({tag, "_timeout"}, 0, words.size(), exp_w.size());
        for (int k = 0; k < exp_w.size(); k++) begin
            if (k < words.size()) begin
                chk({tag, "_word"}, k, words[k], exp_w[k]);
                chk({tag, "_fclk"}, k, fwords[k], P1);
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sdata"},      0, sdata_out,  0);
        chk({tag, "_fclk"},       0, fclk_out,   0);
        chk({tag, "_word_ready"}, 0, word_ready, 1);
        chk({tag, "_busy"},       0, busy,       0);
        chk({tag, "_train_done"}, 0, train_done, 0);
        chk({tag, "_frame_done"}, 0, frame_done, 0);
        chk({tag, "_underflow"},  0, underflow,  0);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        src_on       = 1'b0;
        src_idx      = 0;
        train_req    = 1'b0;
        frame_start  = 1'b0;
        test_ramp_en = 1'b0;
        word_valid   = 1'b0;
        src_vals.delete();
        exp_w.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin : main
        int s, hs, ld, lf, p, er, lw;

        // Reset values, then plain idle words.
        assert_reset();
        check_reset_vals("reset");
        release_reset();
        repeat (3) exp_w.push_back(P1);
        check_slots("idle");
        chk("idle_busy", 0, busy, 0);

        // Training burst.
        assert_reset();
        release_reset();
        s  = 24 + int'($urandom_range(1, 23));
        hs = s / 24 + 1;
        pulse_req(1'b1, 1'b0, s);
        for (int k = 0; k < hs; k++) exp_w.push_back(P1);
        for (int i = 0; i < TW; i++) exp_w.push_back((i % 2 == 0) ? P1 : P2);
        repeat (2) exp_w.push_back(P1);
        goto_edge(24 * (hs + 5) + 3);
        chk("train_busy", 0, busy, 1);
        ld = 24 * (hs + TW - 1);
        goto_edge(ld - 1);
        chk("train_done_before", 0, train_done, 0);
        goto_edge(ld);
        chk("train_done_pulse", 0, train_done, 1);
        goto_edge(ld + 1);
        chk("train_done_after", 0, train_done, 0);
        chk("train_busy_end", 0, busy, 0);
        check_slots("train");

        // Line from a continuously streaming source with random data.
        assert_reset();
        for (int i = 0; i < CH; i++) src_vals.push_back(24'($urandom()));
        stall_after = 1 << 30;
        resume_edge = 0;
        src_on      = 1'b1;
        release_reset();
        s  = 48 + int'($urandom_range(1, 23));
        hs = s / 24 + 1;
        pulse_req(1'b0, 1'b1, s);
        for (int k = 0; k < hs; k++) exp_w.push_back(P1);
        exp_w.push_back(P2);
        for (int i = 0; i < CH; i++) exp_w.push_back(src_vals[i]);
        repeat (2) exp_w.push_back(P1);
        goto_edge(24 * (hs + 40) + 5);
        chk("stream_busy", 0, busy, 1);
        lf = 24 * (hs + CH);
        goto_edge(lf - 1);
        chk("stream_frame_done_before", 0, frame_done, 0);
        goto_edge(lf);
        chk("stream_frame_done_pulse", 0, frame_done, 1);
        goto_edge(lf + 1);
        chk("stream_frame_done_after", 0, frame_done, 0);
        check_slots("stream");
        chk("stream_underflow", 0, underflow, 0);
        chk("stream_busy_end", 0, busy, 0);

        // Source stalls after ten words and resumes late in the line.
        assert_reset();
        for (int i = 0; i < CH; i++) src_vals.push_back(24'(i + 1));
        stall_after = 10;
        src_on      = 1'b1;
        s  = 24 + int'($urandom_range(1, 23));
        hs = s / 24 + 1;
        er = 24 * (hs + 1 + 100) + int'($urandom_range(1, 23));
        resume_edge = er;
        release_reset();
        pulse_req(1'b0, 1'b1, s);
        for (int k = 0; k < hs; k++) exp_w.push_back(P1);
        exp_w.push_back(P2);
        p = 0;
        for (int i = 0; i < CH; i++) begin
            lw = 24 * (hs + 1 + i);
            if (p < 10 || er < lw) begin
                exp_w.push_back(src_vals[p]);
                p++;
            end else begin
                exp_w.push_back(24'h000000);
            end
        end
        exp_w.push_back(P1);
        goto_edge(24 * (hs + 1 + 9) + 1);
        chk("stall_underflow_before", 0, underflow, 0);
        goto_edge(24 * (hs + 1 + 10) + 1);
        chk("stall_underflow_set", 0, underflow, 1);
        lf = 24 * (hs + CH);
        goto_edge(lf);
        chk("stall_frame_done", 0, frame_done, 1);
        check_slots("stall");
        chk("stall_underflow_sticky", 0, underflow, 1);

        // Test ramp: channel index words, prefilled source left untouched.
        assert_reset();
        src_vals.push_back(24'($urandom()));
        stall_after = 1 << 30;
        resume_edge = 0;
        src_on      = 1'b1;
        release_reset();
        test_ramp_en = 1'b1;
        s  = 24 + int'($urandom_range(1, 23));
        hs = s / 24 + 1;
        pulse_req(1'b0, 1'b1, s);
        for (int k = 0; k < hs; k++) exp_w.push_back(P1);
        exp_w.push_back(P2);
        for (int i = 0; i < CH; i++) exp_w.push_back(24'(i));
        exp_w.push_back(P1);
        goto_edge(24 * (hs + CH));
        chk("ramp_frame_done", 0, frame_done, 1);
        check_slots("ramp");
        chk("ramp_word_ready", 0, word_ready, 0);
        chk("ramp_underflow", 0, underflow, 0);

        // Simultaneous requests: training first, then the line, then reset mid-data.
        assert_reset();
        for (int i = 0; i < CH; i++) src_vals.push_back(24'($urandom()));
        stall_after = 1 << 30;
        resume_edge = 0;
        src_on      = 1'b1;
        release_reset();
        s  = 24 + int'($urandom_range(1, 23));
        hs = s / 24 + 1;
        pulse_req(1'b1, 1'b1, s);
        for (int k = 0; k < hs; k++) exp_w.push_back(P1);
        for (int i = 0; i < TW; i++) exp_w.push_back((i % 2 == 0) ? P1 : P2);
        exp_w.push_back(P2);
        for (int i = 0; i < 20; i++) exp_w.push_back(src_vals[i]);
        check_slots("both");
        chk("both_busy_data", 0, busy, 1);
        er = 24 * (hs + TW + 1 + 25) + int'($urandom_range(1, 20));
        goto_edge(er);
        rst_n = 1'b0;
        #2;
        check_reset_vals("midreset");
        src_on = 1'b0;
        repeat (3) @(negedge clk);
        exp_w.delete();
        release_reset();
        repeat (4) exp_w.push_back(P1);
        check_slots("post_reset");
        chk("post_reset_busy", 0, busy, 0);
        chk("post_reset_underflow", 0, underflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
